// File: rtl/data_mem_responder.sv
// Single-port word memory that responds on a req/gnt/r_valid data-memory bus.
// Grant and read-response latency are set by parameters; one transaction in flight at a time.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned GNT_DELAY    = 0,
  parameter int unsigned RVALID_DELAY = 1
) (
  input  logic                  CLK,
  input  logic                  RES,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  gnt,
  output logic                  r_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WIDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned MAX_DLY = (GNT_DELAY > RVALID_DELAY) ? GNT_DELAY : RVALID_DELAY;
  localparam int unsigned CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

  localparam logic [CNT_W-1:0] GNT_LOAD  = CNT_W'((GNT_DELAY > 0) ? GNT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'((RVALID_DELAY > 0) ? RVALID_DELAY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_WAIT = 2'd1,
    RESP_WAIT  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] stage_q, stage_d;
  logic                  stage_oor_q, stage_oor_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  r_valid_q, r_valid_d;
  logic                  rd_err_q, rd_err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [WIDX_W-1:0]     word_idx_c;
  logic [IDX_W-1:0]      mem_idx_c;
  logic                  oor_c;
  logic [DATA_WIDTH-1:0] mem_rd_c;
  logic                  gnt_c;
  logic                  hs_c;
  logic                  mem_we_c;
  logic                  unused_addr_lsb;

  // Word index decode; byte offset is ignored and high index bits never alias.
  assign word_idx_c      = addr[ADDR_WIDTH-1:2];
  assign mem_idx_c       = word_idx_c[IDX_W-1:0];
  assign oor_c           = {1'b0, word_idx_c} >= (WIDX_W + 1)'(DEPTH_WORDS);
  assign unused_addr_lsb = ^addr[1:0];
  assign mem_rd_c        = mem_q[mem_idx_c];

  // Grant is combinational so a zero-delay responder accepts in the request cycle.
  always_comb begin
    gnt_c = 1'b0;
    unique case (state_q)
      IDLE:       gnt_c = (GNT_DELAY == 0) ? req : 1'b0;
      GRANT_WAIT: gnt_c = req && (cnt_q == '0);
      default:    gnt_c = 1'b0;
    endcase
    if (RES) begin
      gnt_c = 1'b0;
    end
  end

  assign hs_c     = req & gnt_c;
  assign mem_we_c = hs_c & we & ~oor_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    stage_oor_d = stage_oor_q;

    unique case (state_q)
      IDLE: begin
        if (GNT_DELAY == 0) begin
          if (hs_c && !we) begin
            stage_d     = oor_c ? '0 : mem_rd_c;
            stage_oor_d = oor_c;
            state_d     = RESP_WAIT;
            cnt_d       = RESP_LOAD;
          end
        end else if (req) begin
          state_d = GRANT_WAIT;
          cnt_d   = GNT_LOAD;
        end
      end
      GRANT_WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (we) begin
          state_d = IDLE;
        end else begin
          stage_d     = oor_c ? '0 : mem_rd_c;
          stage_oor_d = oor_c;
          state_d     = RESP_WAIT;
          cnt_d       = RESP_LOAD;
        end
      end
      RESP_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Response outputs are registered: a pulse is due in the cycle the FSM sits in RESP_WAIT with cnt=0.
    r_valid_d = (state_d == RESP_WAIT) && (cnt_d == '0);
    rd_err_d  = r_valid_d && stage_oor_d;
    rdata_d   = r_valid_d ? stage_d : rdata_q;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stage_q     <= '0;
      stage_oor_q <= 1'b0;
      rdata_q     <= '0;
      r_valid_q   <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      stage_oor_q <= stage_oor_d;
      rdata_q     <= rdata_d;
      r_valid_q   <= r_valid_d;
      rd_err_q    <= rd_err_d;
    end
  end

  // Storage is deliberately not reset so contents survive RES.
  always_ff @(posedge CLK) begin
    if (mem_we_c) begin
      mem_q[mem_idx_c] <= wdata;
    end
  end

  assign gnt     = gnt_c;
  assign r_valid = r_valid_q;
  assign rdata   = rdata_q;
  assign err     = rd_err_q | (hs_c & we & oor_c);

endmodule
